// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back queue entry type.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending register-file writes.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (flushes the queue)
//   push_i          enqueue push_entry_i at the tail (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   upd_en_i        overwrite data of entry upd_idx_i with upd_data_i
//   head_o          oldest entry
//   entries_o       raw storage, indexed by physical slot
//   valid_o         per-slot occupancy
//   rd_ptr_o        physical slot of the head
//   full_o, empty_o occupancy flags
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  input  logic                         upd_en_i,
  input  logic [$clog2(DEPTH)-1:0]     upd_idx_i,
  input  logic [REG_DATA_W-1:0]        upd_data_i,
  output wb_entry_t                    head_o,
  output wb_entry_t [DEPTH-1:0]        entries_o,
  output logic [DEPTH-1:0]             valid_o,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next state; power-of-two depth gives natural wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every consumer qualifies it with valid_o/empty_o.
  always_ff @(posedge clk) begin
    if (push_ok)  mem_q[wr_ptr_q]       <= push_entry_i;
    if (upd_en_i) mem_q[upd_idx_i].data <= upd_data_i;
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back buffer between the ALU and the register-file write port, with
// youngest-match forwarding for two read addresses.
// Optional feature: define WB_COALESCE_EN to merge a new write into the
// youngest queued non-head entry for the same register.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       result handshake; in_rd/in_data destination/value
//   wb_stall                write port unavailable this cycle
//   A3/WD3/WE3              register-file write port
//   A1/A2 -> hit1/fwd1, hit2/fwd2   forwarding lookups
//   busy                    queue non-empty
module regfile_writeback
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_stall,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full, empty;
  logic                  accept, rd_nonzero, push, upd_en;
  logic                  co_hit;
  logic [PTR_W-1:0]      co_idx;
  logic [PTR_W-1:0]      idx;
  wb_entry_t             new_entry;

  assign in_ready   = !full;
  assign busy       = !empty;
  assign accept     = in_valid && in_ready;
  assign rd_nonzero = (REG_ADDR_W'(in_rd) != REG_ZERO);
  assign push       = accept && rd_nonzero && !co_hit;
  assign upd_en     = accept && rd_nonzero && co_hit;

  assign new_entry.addr = REG_ADDR_W'(in_rd);
  assign new_entry.data = REG_DATA_W'(in_data);

  // Drain: the head is presented whenever the queue holds something.
  assign WE3 = busy && !wb_stall;
  assign A3  = busy ? ADDR_W'(head.addr) : '0;
  assign WD3 = busy ? DATA_W'(head.data) : '0;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    fwd1   = '0;
    fwd2   = '0;
    co_hit = 1'b0;
    co_idx = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx] && (A1 != '0) && (entries[idx].addr == REG_ADDR_W'(A1))) begin
        hit1 = 1'b1;
        fwd1 = DATA_W'(entries[idx].data);
      end
      if (valid[idx] && (A2 != '0) && (entries[idx].addr == REG_ADDR_W'(A2))) begin
        hit2 = 1'b1;
        fwd2 = DATA_W'(entries[idx].data);
      end
`ifdef WB_COALESCE_EN
      // The head is excluded: it may be leaving this very cycle.
      if ((k != 0) && valid[idx] && (entries[idx].addr == REG_ADDR_W'(in_rd))) begin
        co_hit = 1'b1;
        co_idx = idx;
      end
`endif
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_entry_i(new_entry),
    .pop_i       (WE3),
    .upd_en_i    (upd_en),
    .upd_idx_i   (co_idx),
    .upd_data_i  (REG_DATA_W'(in_data)),
    .head_o      (head),
    .entries_o   (entries),
    .valid_o     (valid),
    .rd_ptr_o    (rd_ptr),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_stall;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  ent_t q[$];
  ent_t wr_log[$];
  bit   model_ok = 0;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall),
    .A3(A3), .WD3(WD3), .WE3(WE3), .A1(A1), .A2(A2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: checks current outputs, then applies the coming edge.
  always @(negedge clk) begin
    ent_t        t;
    logic        e_busy, e_h1, e_h2, pop, acc;
    logic [31:0] e_f1, e_f2;
    int          co;
    if (model_ok) begin
      e_busy = (q.size() != 0);
      e_h1 = 1'b0; e_f1 = '0; e_h2 = 1'b0; e_f2 = '0;
      for (int i = 0; i < q.size(); i++) begin
        if (A1 != 0 && q[i].a == A1) begin e_h1 = 1'b1; e_f1 = q[i].d; end
        if (A2 != 0 && q[i].a == A2) begin e_h2 = 1'b1; e_f2 = q[i].d; end
      end
      chk("busy",     32'(busy),     32'(e_busy));
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("WE3",      32'(WE3),      32'(e_busy && !wb_stall));
      chk("A3",       32'(A3),       e_busy ? 32'(q[0].a) : 32'd0);
      chk("WD3",      WD3,           e_busy ? q[0].d : 32'd0);
      chk("hit1",     32'(hit1),     32'(e_h1));
      chk("fwd1",     fwd1,          e_f1);
      chk("hit2",     32'(hit2),     32'(e_h2));
      chk("fwd2",     fwd2,          e_f2);
      if (WE3 === 1'b1) begin
        t.a = A3; t.d = WD3;
        wr_log.push_back(t);
      end
    end
    if (!rst_n) begin
      q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      pop = (q.size() != 0) && !wb_stall;
      acc = in_valid && (q.size() != DEPTH);
      co  = -1;
`ifdef WB_COALESCE_EN
      if (acc && in_rd != 0)
        for (int i = 1; i < q.size(); i++) if (q[i].a == in_rd) co = i;
`endif
      if (co > 0) q[co].d = in_data;
      if (pop) t = q.pop_front();
      if (acc && in_rd != 0 && co < 0) begin
        t.a = in_rd; t.d = in_data;
        q.push_back(t);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b1; in_rd = rd; in_data = d;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    chk("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      #1;
      if (!busy) return;
      step();
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_log(input string nm, input ent_t exp[$]);
    chk({nm, "_count"}, 32'(wr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      chk({nm, "_addr"}, 32'(wr_log[i].a), 32'(exp[i].a));
      chk({nm, "_data"}, wr_log[i].d, exp[i].d);
    end
  endtask

  initial begin
    ent_t exp[$];
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
    wb_stall = 1'b0; A1 = '0; A2 = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state and single-write latency
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_WE3",      32'(WE3),      32'd0);
    chk("rst_A3",       32'(A3),       32'd0);
    chk("rst_WD3",      WD3,           32'd0);
    chk("rst_fwd1",     fwd1,          32'd0);
    push(5'd5, 32'hDEADBEEF);
    #1;
    chk("lat_WE3", 32'(WE3), 32'd1);
    chk("lat_A3",  32'(A3),  32'd5);
    chk("lat_WD3", WD3,      32'hDEADBEEF);
    step();
    chk("lat_WE3_after",  32'(WE3),  32'd0);
    chk("lat_busy_after", 32'(busy), 32'd0);

    // Fill under stall, fifth push held until a slot drains
    wr_log.delete();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 10));
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'd50;
    step(); step();
    chk("full_held_ready", 32'(in_ready), 32'd0);
    chk("full_held_WE3",   32'(WE3),      32'd0);
    chk("full_held_A3",    32'(A3),       32'd1);
    wb_stall = 1'b0;
    push(5'd5, 32'd50);
    drain();
    exp.delete();
    for (int i = 1; i <= 5; i++) exp.push_back(ent_t'{5'(i), 32'(i * 10)});
    check_log("order", exp);

    // Register 0 is accepted and dropped
    wr_log.delete();
    push(5'd0, 32'd7);
    for (int i = 0; i < 3; i++) begin
      chk("r0_busy", 32'(busy), 32'd0);
      chk("r0_WE3",  32'(WE3),  32'd0);
      step();
    end
    chk("r0_writes", 32'(wr_log.size()), 32'd0);

    // Youngest-match forwarding
    wb_stall = 1'b1;
    push(5'd3, 32'd11);
    push(5'd3, 32'd22);
    A1 = 5'd3; A2 = 5'd4;
    #1;
    chk("fw_hit1", 32'(hit1), 32'd1);
    chk("fw_fwd1", fwd1,      32'd22);
    chk("fw_hit2", 32'(hit2), 32'd0);
    chk("fw_fwd2", fwd2,      32'd0);
    A1 = '0; A2 = '0; wb_stall = 1'b0;
    drain();

    // Reset flushes queued writes
    wb_stall = 1'b1;
    push(5'd1, 32'd100); push(5'd2, 32'd200); push(5'd3, 32'd300);
    wr_log.delete();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("flush_busy",  32'(busy),     32'd0);
    chk("flush_WE3",   32'(WE3),      32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    wb_stall = 1'b0;
    repeat (5) step();
    chk("flush_writes", 32'(wr_log.size()), 32'd0);

    // Duplicate destinations: coalesced or drained in order
    wb_stall = 1'b1;
    wr_log.delete();
    push(5'd7, 32'd1); push(5'd9, 32'd2); push(5'd9, 32'd3);
    wb_stall = 1'b0;
    drain();
    exp.delete();
    exp.push_back(ent_t'{5'd7, 32'd1});
`ifndef WB_COALESCE_EN
    exp.push_back(ent_t'{5'd9, 32'd2});
`endif
    exp.push_back(ent_t'{5'd9, 32'd3});
    check_log("dup", exp);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_rd    = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      wb_stall = ($urandom_range(0, 99) < 35);
      A1       = 5'($urandom_range(0, 7));
      A2       = 5'($urandom_range(0, 7));
      rst_n    = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
    drain();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side counterpart of the register-file read path. Accepts ALU results tagged with a destination register and buffers them in a small in-order queue.
- Drains the queue into the register file write port (A3/WD3/WE3), one write per cycle.
- Gives the read side a youngest-match forwarding lookup for two read addresses, so operands still waiting in the queue are never read stale.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- DATA_W, 32, result/data width.
- ADDR_W, 5, register number width (32 registers).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  result offered this cycle.
- in_ready  output  1  queue can accept this cycle.
- in_rd  input  ADDR_W  destination register number.
- in_data  input  DATA_W  result value (e.g. ALUResult).
- wb_stall  input  1  register-file write port unavailable this cycle.
- A3  output  ADDR_W  write address to register file.
- WD3  output  DATA_W  write data to register file.
- WE3  output  1  write enable to register file.
- A1  input  ADDR_W  read lookup address 1 (rs).
- A2  input  ADDR_W  read lookup address 2 (rt).
- hit1, hit2  output  1  a queued write to A1/A2 is pending.
- fwd1, fwd2  output  DATA_W  youngest pending data for A1/A2.
- busy  output  1  queue non-empty.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wr_ptr=rd_ptr=0, count=0.
  - WE3=0, A3=0, WD3=0, busy=0, hit1=hit2=0, fwd1=fwd2=0, in_ready=1 from the first cycle after reset.
  - Reset mid-operation flushes all queued writes; they are never written.
- Accept:
  - A transfer occurs when in_valid && in_ready at a clock edge.
  - in_ready = (count != DEPTH), from registered state only. It does not depend on a same-cycle pop, so a full queue accepts nothing that cycle even while draining.
- Register 0:
  - A transfer with in_rd==0 completes the handshake (in_ready honoured) but is discarded: no enqueue, count unchanged.
- Drain:
  - WE3 = busy && !wb_stall.
  - A3/WD3 = head entry when busy, 0 when empty.
  - Pop on every cycle WE3=1. All outputs are combinational from registered state.
  - Minimum latency: an entry accepted at edge N appears on WE3 in the cycle after edge N.
- Simultaneous push and pop (queue not full): count unchanged, both pointers advance.
- Pointers:
  - log2(DEPTH) bits, wrapping modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH, with no overflow or underflow.
  - Order of writes to the register file equals acceptance order.
- Stall:
  - wb_stall=1 holds the head; A3/WD3 stay stable and WE3=0.
  - Accepts continue until full.
- Forwarding:
  - hitN=1 if any valid queued entry has addr==AN and AN!=0.
  - fwdN = data of the youngest matching entry (closest to wr_ptr); 0 when no hit.
  - The entry being popped this cycle still counts as a hit, because the register file write is not yet visible.
  - An input being accepted this cycle is not visible to the lookup.
- No data width conversion; in_data is stored verbatim.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - An accepted write whose in_rd matches a queued non-head entry (the youngest match) overwrites that entry's data in place instead of enqueueing. count is unchanged.
  - in_ready is still (count != DEPTH), so coalescing does not admit writes while full.
  - A match against the head alone, or a head that is popping this cycle, enqueues normally.
- Not defined:
  - Every non-zero write enqueues. Duplicates to the same register are drained in order, and the last one wins in the register file.

Decomposition:
- Package rf_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=0;
  - typedef wb_entry_t, a packed struct {addr, data}.
- Sub-module wb_fifo:
  - storage array of wb_entry_t, pointers, count, full/empty;
  - exposes all entries plus a per-entry valid vector for the lookup.
- The top level regfile_writeback holds the handshake, register-0 filter, drain logic, forwarding priority search and optional coalescing.

Test Plan:
- Reset then single write (in_rd=5, in_data=32'hDEADBEEF) → next cycle WE3=1, A3=5, WD3=DEADBEEF. The following cycle WE3=0 and busy=0.
- wb_stall=1, push rd 1..5 with data 10..50 → in_ready=0 after 4 accepts and 5th held. Release stall → writes 1..4 in order, then 5 accepted and written last.
- Push rd=0, data=7 → handshake completes; WE3 never asserts; busy=0.
- Stall, push (rd=3,11), then (rd=3,22); A1=3 → hit1=1, fwd1=22. A2=4 → hit2=0, fwd2=0.
- Assert rst_n=0 with 3 entries queued → next cycle busy=0, WE3=0, and none of the queued writes ever appears.
- With WB_COALESCE_EN defined: stall, push (rd=7,1),(rd=9,2),(rd=9,3) → count=2; drain gives (7,1),(9,3). Without the macro: count=3; drain gives (7,1),(9,2),(9,3).
